// File: rtl/mem_fifo_pkg.sv
// Shared sizing for the FIFO controller, its Memory block and the wrapper.
package mem_fifo_pkg;

   localparam int DATA_W = 2;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   // Occupancy needs one extra bit so that a completely full FIFO is representable.
   typedef logic [ADDR_W:0] count_t;

endpackage

// File: rtl/Memory.sv
// 16 x 2 storage array: write lands at the clock edge, read is combinational.
module Memory
   import mem_fifo_pkg::*;
#(
   parameter int DATA_W = mem_fifo_pkg::DATA_W,
   parameter int ADDR_W = mem_fifo_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] index_wr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              mem_rd,
   input  logic [ADDR_W-1:0] index_rd,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] mem_q [(1<<ADDR_W)];

   // Storage write; no reset, contents survive rst and clr.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem_q[index_wr] <= data_in;
      end
   end

   // Read data is only driven while a read is requested.
   always_comb begin
      data_out = '0;
      if (mem_rd) begin
         data_out = mem_q[index_rd];
      end
   end

endmodule

// File: rtl/mem_fifo.sv
// System-level FIFO: mem_fifo_ctrl driving a Memory instance.
// Optional feature: define MEM_FIFO_ERR_EN to expose ovf_err/unf_err.
module mem_fifo
   import mem_fifo_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic              full,
   output logic              empty,
   output count_t            count
`ifdef MEM_FIFO_ERR_EN
   ,
   output logic              ovf_err,
   output logic              unf_err
`endif
);

   logic              mem_wr;
   logic [ADDR_W-1:0] index_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic [ADDR_W-1:0] index_rd;
   logic [DATA_W-1:0] mem_rdata;

   mem_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .mem_wr    (mem_wr),
      .index_wr  (index_wr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .index_rd  (index_rd),
      .mem_rdata (mem_rdata)
`ifdef MEM_FIFO_ERR_EN
      ,
      .ovf_err   (ovf_err),
      .unf_err   (unf_err)
`endif
   );

   Memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
      .clk      (clk),
      .mem_wr   (mem_wr),
      .index_wr (index_wr),
      .data_in  (mem_wdata),
      .mem_rd   (mem_rd),
      .index_rd (index_rd),
      .data_out (mem_rdata)
   );

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Circular-buffer controller for the Memory block: owns the write/read pointers,
// occupancy count and full/empty flags, and registers the memory read data.
// Optional feature: define MEM_FIFO_ERR_EN to add sticky ovf_err/unf_err outputs.
module mem_fifo_ctrl
   import mem_fifo_pkg::*;
#(
   parameter int DATA_W = mem_fifo_pkg::DATA_W,
   parameter int ADDR_W = mem_fifo_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] index_wr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] index_rd,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_FIFO_ERR_EN
   ,
   output logic              ovf_err,
   output logic              unf_err
`endif
);

   localparam int FIFO_DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_nxt;
   logic              op_en;
   logic              push_ok;
   logic              pop_ok;

   // When full, a push is still accepted alongside a pop: the slot being read
   // is the slot being written, and the read returns the old entry because the
   // memory write only lands at the edge.
   assign op_en   = ~rst & ~clr;
   assign pop_ok  = op_en & pop & ~empty;
   assign push_ok = op_en & push & (~full | pop);

   assign mem_wr    = push_ok;
   assign index_wr  = wr_ptr;
   assign mem_wdata = push_data;
   assign mem_rd    = pop_ok;
   assign index_rd  = rd_ptr;

   // Occupancy after this edge; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok) begin
         count_nxt = count + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
         count_nxt = count - CNT_ONE;
      end
   end

   // Pointers, occupancy and status flags; clr behaves like rst here.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CNT_FULL);
      end
   end

   // Read-data register: clr holds the last value, only rst zeroes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_data  <= '0;
         pop_valid <= 1'b0;
      end else if (clr) begin
         pop_valid <= 1'b0;
      end else begin
         pop_valid <= pop_ok;
         if (pop_ok) begin
            pop_data <= mem_rdata;
         end
      end
   end

`ifdef MEM_FIFO_ERR_EN
   // Sticky flags for dropped requests; rejected ops never change FIFO state.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (push && full && !pop) begin
            ovf_err <= 1'b1;
         end
         if (pop && empty) begin
            unf_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: a queue-based FIFO model plus a plain array standing
// in for the Memory block. Directed scenarios pin the model with literal values,
// then a long randomized run is compared against the model every cycle.
module tb_mem_fifo_ctrl;

   localparam int DW  = 2;
   localparam int AW  = 4;
   localparam int DEP = 16;

   logic          clk = 1'b0;
   logic          rst, clr, push, pop;
   logic [DW-1:0] push_data;
   logic [DW-1:0] pop_data;
   logic          pop_valid, full, empty;
   logic [AW:0]   count;
   logic          mem_wr, mem_rd;
   logic [AW-1:0] index_wr, index_rd;
   logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_FIFO_ERR_EN
   logic          ovf_err, unf_err;
`endif

   always #5 clk = ~clk;

   mem_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .mem_wr    (mem_wr),
      .index_wr  (index_wr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .index_rd  (index_rd),
      .mem_rdata (mem_rdata)
`ifdef MEM_FIFO_ERR_EN
      ,
      .ovf_err   (ovf_err),
      .unf_err   (unf_err)
`endif
   );

   // Stand-in for Memory: edge write, combinational read.
   logic [DW-1:0] tb_mem [DEP];
   always @(posedge clk) begin
      if (mem_wr) tb_mem[index_wr] <= mem_wdata;
   end
   assign mem_rdata = mem_rd ? tb_mem[index_rd] : '0;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: contents as a queue, pointers as positions mod depth.
   logic [DW-1:0] q[$];
   int            m_wp, m_rp;
   logic [DW-1:0] m_pd;
   logic          m_pv;
   logic          m_ovf, m_unf;
   logic          last_mem_wr;
   logic [AW-1:0] last_index_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check strobes, advance the model at the
   // edge, then check registered outputs at the following negedge.
   task automatic step(input logic pu, input logic [DW-1:0] d, input logic po,
                       input logic c, input logic r);
      logic pa, ua;
      int   sz;
      rst = r; clr = c; push = pu; pop = po; push_data = d;
      sz = q.size();
      pa = !r && !c && po && (sz > 0);
      ua = !r && !c && pu && ((sz < DEP) || po);
      #1;
      chk("mem_wr",    32'(mem_wr),    32'(ua));
      chk("mem_rd",    32'(mem_rd),    32'(pa));
      chk("index_wr",  32'(index_wr),  32'(m_wp));
      chk("index_rd",  32'(index_rd),  32'(m_rp));
      chk("mem_wdata", 32'(mem_wdata), 32'(d));
      last_mem_wr   = mem_wr;
      last_index_wr = index_wr;
      @(posedge clk);
      if (r || c) begin
         q.delete();
         m_wp = 0; m_rp = 0; m_pv = 1'b0;
         m_ovf = 1'b0; m_unf = 1'b0;
         if (r) m_pd = '0;
      end else begin
         if (pu && sz == DEP && !po) m_ovf = 1'b1;
         if (po && sz == 0) m_unf = 1'b1;
         m_pv = pa;
         if (pa) begin
            m_pd = q.pop_front();
            m_rp = (m_rp + 1) % DEP;
         end
         if (ua) begin
            q.push_back(d);
            m_wp = (m_wp + 1) % DEP;
         end
      end
      @(negedge clk);
      chk("count",     32'(count),     32'(q.size()));
      chk("empty",     32'(empty),     32'(q.size() == 0));
      chk("full",      32'(full),      32'(q.size() == DEP));
      chk("pop_valid", 32'(pop_valid), 32'(m_pv));
      chk("pop_data",  32'(pop_data),  32'(m_pd));
`ifdef MEM_FIFO_ERR_EN
      chk("ovf_err",   32'(ovf_err),   32'(m_ovf));
      chk("unf_err",   32'(unf_err),   32'(m_unf));
`endif
   endtask

   task automatic do_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
      m_wp = 0; m_rp = 0; m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      last_mem_wr = 1'b0; last_index_wr = '0;
      @(negedge clk);

      // Reset and idle
      do_reset();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_pv",    32'(pop_valid), 32'd0);

      // Fill, overflow attempt, drain in order
      for (int i = 0; i < 16; i++) step(1'b1, DW'(i % 4), 1'b0, 1'b0, 1'b0);
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd16);
      step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
      chk("push17_drop", 32'(last_mem_wr), 32'd0);
`ifdef MEM_FIFO_ERR_EN
      chk("ovf_lit", 32'(ovf_err), 32'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
         chk("drain_pv",   32'(pop_valid), 32'd1);
         chk("drain_data", 32'(pop_data),  32'(i % 4));
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Wrap-around from a fresh start
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, DW'(3 - (i % 4)), 1'b0, 1'b0, 1'b0);
         if (i == 6) chk("wrap_index", 32'(last_index_wr), 32'd0);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
         chk("wrap_data", 32'(pop_data), 32'(3 - (i % 4)));
      end
      chk("wrap_empty", 32'(empty), 32'd1);

      // Full with simultaneous push and pop
      for (int i = 0; i < 16; i++) step(1'b1, DW'(i % 4), 1'b0, 1'b0, 1'b0);
      step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
      chk("fullpp_data",  32'(pop_data), 32'd0);
      chk("fullpp_count", 32'(count),    32'd16);
      for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("fullpp_last", 32'(pop_data), 32'd3);
      chk("fullpp_empty", 32'(empty), 32'd1);

      // Empty with simultaneous push and pop
      step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
      chk("emptypp_pv",    32'(pop_valid), 32'd0);
      chk("emptypp_count", 32'(count),     32'd1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("emptypp_data", 32'(pop_data), 32'd2);

      // clr with 5 queued and push active
      for (int i = 0; i < 6; i++) step(1'b1, DW'(i + 1), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("pre_clr_data", 32'(pop_data), 32'd1);
      step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
      chk("clr_count", 32'(count),    32'd0);
      chk("clr_empty", 32'(empty),    32'd1);
      chk("clr_hold",  32'(pop_data), 32'd1);

      // rst with 5 queued and push active
      for (int i = 0; i < 6; i++) step(1'b1, DW'(i + 2), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_data", 32'(pop_data), 32'd2);
      step(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
      chk("rst_count2", 32'(count),    32'd0);
      chk("rst_empty2", 32'(empty),    32'd1);
      chk("rst_zero",   32'(pop_data), 32'd0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Randomized phases with varying push/pop pressure
      for (int ph = 0; ph < 20; ph++) begin
         int pp, qp;
         pp = (ph % 5 == 0) ? 90 : (ph % 5 == 1) ? 15 : (ph % 5 == 2) ? 50 :
              (ph % 5 == 3) ? 97 : 5;
         qp = (ph % 5 == 3) ? 60 : 100 - pp;
         for (int k = 0; k < 150; k++) begin
            logic pu, po, c, r;
            pu = ($urandom_range(0, 99) < pp);
            po = ($urandom_range(0, 99) < qp);
            c  = ($urandom_range(0, 199) == 0);
            r  = ($urandom_range(0, 399) == 0);
            step(pu, DW'($urandom_range(0, 3)), po, c, r);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_fifo_ctrl.md
# mem_fifo_ctrl

FIFO controller that drives the 16-entry × 2-bit `Memory` block as a circular buffer. It converts a push/pop request interface into `mem_wr`/`index_wr`/`data_in` and `mem_rd`/`index_rd` strobes, and registers the memory's read data. It sits directly upstream of `Memory` and owns the write/read pointers, occupancy count and full/empty status.

## Interface
Parameters:
- `DATA_W`, default 2: entry width; must match `Memory`.
- `ADDR_W`, default 4: index width; depth = 2**ADDR_W = 16.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  synchronous flush (empties the FIFO)
- `push`  in  1  write request
- `push_data`  in  DATA_W  data to enqueue
- `pop`  in  1  read request
- `pop_data`  out  DATA_W  dequeued data, registered
- `pop_valid`  out  1  one-cycle pulse: `pop_data` updated this cycle
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  ADDR_W+1  occupancy, 0..16
- `mem_wr`  out  1  to `Memory.mem_wr`
- `index_wr`  out  ADDR_W  to `Memory.index_wr`
- `mem_wdata`  out  DATA_W  to `Memory.data_in`
- `mem_rd`  out  1  to `Memory.mem_rd`
- `index_rd`  out  ADDR_W  to `Memory.index_rd`
- `mem_rdata`  in  DATA_W  from `Memory.data_out` (combinational read)

## Operation
- Accepted push: `push & (~full | pop)`. Accepted pop: `pop & ~empty`. Both are masked to 0 while `rst` or `clr` is high.
- `mem_wr` = accepted push. `index_wr` = `wr_ptr`. `mem_wdata` = `push_data`. All are combinational, and `Memory` captures at the next edge.
- `mem_rd` = accepted pop. `index_rd` = `rd_ptr`. On that edge, `pop_data <= mem_rdata` and `pop_valid <= 1`.
- Pointers are ADDR_W bits and wrap 15→0 naturally. Each pointer increments on its accepted op.
- Count update: +1 on push-only, −1 on pop-only, unchanged on both or neither.
- Full with simultaneous push and pop: both are accepted. The write targets `wr_ptr == rd_ptr`, and the combinational read returns the old entry because the memory write lands at the edge. Count stays 16.
- Empty with simultaneous push and pop: only the push is accepted; there is no fall-through. `pop_valid` stays 0.
- Rejected ops (push when full without pop, pop when empty) are dropped, and state is unchanged.
- `clr`: pointers and count go to 0, `empty` goes to 1, and `pop_valid` goes to 0. `pop_data` is held. Memory contents are untouched.
- Reset values: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `empty`=1, `full`=0, `pop_valid`=0, `pop_data`=0. `mem_wr`=0 and `mem_rd`=0 while `rst` is high. `rst` mid-operation discards all queued entries.

## Timing
- `full`, `empty` and `count` are registered and reflect ops accepted at the previous edge.
- Pop latency is 1 cycle: pop accepted in cycle N gives `pop_data`/`pop_valid` in N+1.
- Push-to-pop minimum: push in N, `empty`=0 in N+1, pop in N+1, data in N+2.
- Sustained push+pop throughput is 1 entry/cycle.
- `pop_valid` is a single-cycle pulse per accepted pop and is never held.

## Configuration
- `MEM_FIFO_ERR_EN` defined: adds outputs `ovf_err` (1 bit) and `unf_err` (1 bit).
  - `ovf_err` sets on a rejected push.
  - `unf_err` sets on a rejected pop.
  - Both are sticky, cleared by `rst` or `clr`, and reset to 0.
- `MEM_FIFO_ERR_EN` undefined: these ports and their logic are absent, and rejected ops are silently dropped.

## Structure
- Package `mem_fifo_pkg` holds `DATA_W`=2, `ADDR_W`=4 and `DEPTH`=16 as localparams, plus a `count_t` typedef of width ADDR_W+1.
- No sub-module inside the controller.
- A wrapper `mem_fifo` instantiates `mem_fifo_ctrl` + `Memory` for system use and for the bench.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `count`=0, `pop_valid`=0, `mem_wr`=`mem_rd`=0.
- Push 16 values 0,1,2,3,0,1,… → `full`=1 and `count`=16. A 17th push is dropped (`mem_wr`=0; `ovf_err`=1 if enabled). Then 16 pops return 0,1,2,3,… in order, each 1 cycle after its pop.
- Wrap-around:
  - Push 10, pop 10, then push 10 more (`index_wr` wraps 15→0 at the 7th).
  - Then pop all 10 → data in order, `empty`=1.
- Full with simultaneous push 2'b11 and pop:
  - The pop returns the oldest entry, and `count` stays 16.
  - 16 further pops end with 2'b11.
- Empty with simultaneous push 2'b10 and pop: `pop_valid`=0 and `count`=1. The next pop returns 2'b10.
- `clr` asserted with 5 entries queued and push active → `count`=0, `empty`=1 next cycle, push ignored, `pop_data` unchanged. `rst` with 5 entries behaves the same, and additionally `pop_data`=0.
